// File: rtl/ahb_resp_gen_if.sv
// ahb_resp_gen_if
//   Address-phase request and data-phase response signals shared between
//   an AHB master-side driver and the ahb_resp_gen slave response block.
//   Parameter:
//     WAIT_W     width of the per-transfer wait-state request
//   Signals:
//     hsel       slave select for the current address phase
//     htrans     transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
//     hready_in  bus HREADY; an address phase is valid only when high
//     resp_type  completion type for the transfer being accepted
//     resp_wait  wait states for the transfer being accepted
//     hready     slave HREADYOUT
//     hresp      slave HRESP
//     resp_done  pulse in the final data-phase cycle of each transfer
//   Modports: master drives the request side, slave drives the response side.
interface ahb_resp_gen_if #(
  parameter int WAIT_W = 4
);
  logic              hsel;
  logic [1:0]        htrans;
  logic              hready_in;
  logic [1:0]        resp_type;
  logic [WAIT_W-1:0] resp_wait;
  logic              hready;
  logic [1:0]        hresp;
  logic              resp_done;

  modport master (
    output hsel, htrans, hready_in, resp_type, resp_wait,
    input  hready, hresp, resp_done
  );

  modport slave (
    input  hsel, htrans, hready_in, resp_type, resp_wait,
    output hready, hresp, resp_done
  );
endinterface

// File: rtl/ahb_resp_gen.sv
// ahb_resp_gen
//   AHB slave response generator. Each accepted transfer gets a programmable
//   number of wait states, then completes with OKAY (one ready cycle) or with
//   the two-cycle ERROR / RETRY / SPLIT response. All bus outputs are
//   registered.
//   Parameters:
//     WAIT_W    width of resp_wait
//     MAX_WAIT  wait-state ceiling; larger requests are clamped
//     CNT_W     width of err_cnt
//   Ports:
//     hclk      AHB clock, rising edge
//     hreset    asynchronous active-low reset
//     bus       ahb_resp_gen_if.slave (request in, hready/hresp/resp_done out)
//     err_clr   synchronous clear of err_cnt
//     err_cnt   number of completed ERROR responses (saturating)
//   Optional feature macro: AHB_RESP_ERRCNT_EN builds the error counter;
//   without it err_cnt is tied to zero and err_clr is ignored.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | no transfer in data phase; hready=1, hresp=OKAY
//   S_WAIT  | inserting wait states; hready=0, hresp=OKAY
//   S_FIRST | first cycle of two-cycle response; hready=0, hresp=type_q
//   S_LAST  | completing cycle; hready=1, hresp=type_q, resp_done=1
module ahb_resp_gen #(
  parameter int WAIT_W   = 4,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 8
) (
  input  logic             hclk,
  input  logic             hreset,
  ahb_resp_gen_if.slave    bus,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [WAIT_W-1:0] MAX_W   = WAIT_W'(MAX_WAIT);
  localparam logic [1:0]        R_OKAY  = 2'b00;
  localparam logic [1:0]        R_ERROR = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_WAIT  = 2'b01,
    S_FIRST = 2'b10,
    S_LAST  = 2'b11
  } state_t;

  state_t            state, state_n;
  logic [WAIT_W-1:0] cnt, cnt_n;
  logic [1:0]        type_q, type_n;
  logic [WAIT_W-1:0] w_clamp;
  logic              accept;

  always_comb begin
    accept  = bus.hsel & bus.htrans[1] & bus.hready_in;
    w_clamp = (bus.resp_wait > MAX_W) ? MAX_W : bus.resp_wait;
    state_n = S_IDLE;
    cnt_n   = cnt;
    type_n  = type_q;
    case (state)
      S_IDLE, S_LAST: begin
        if (accept) begin
          type_n = bus.resp_type;
          if (w_clamp != '0) begin
            state_n = S_WAIT;
            cnt_n   = w_clamp;
          end else if (bus.resp_type != R_OKAY) begin
            state_n = S_FIRST;
          end else begin
            state_n = S_LAST;
          end
        end
      end
      S_WAIT: begin
        cnt_n = cnt - 1'b1;
        // cnt==0 cannot occur legally here; exit anyway rather than wrap.
        if (cnt <= WAIT_W'(1))
          state_n = (type_q != R_OKAY) ? S_FIRST : S_LAST;
        else
          state_n = S_WAIT;
      end
      S_FIRST: state_n = S_LAST;
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are valid in the same
  // cycle the state register holds that state.
  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      type_q        <= R_OKAY;
      bus.hready    <= 1'b1;
      bus.hresp     <= R_OKAY;
      bus.resp_done <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      type_q        <= type_n;
      bus.hready    <= (state_n == S_IDLE) || (state_n == S_LAST);
      bus.hresp     <= ((state_n == S_FIRST) || (state_n == S_LAST)) ? type_n : R_OKAY;
      bus.resp_done <= (state_n == S_LAST);
    end
  end

`ifdef AHB_RESP_ERRCNT_EN
  // Every transition into S_LAST is a fresh completion, including
  // back-to-back LAST->LAST, so it counts once per transfer.
  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if ((state_n == S_LAST) && (type_n == R_ERROR) && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`else
  logic err_clr_unused;
  assign err_clr_unused = err_clr;
  assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_ahb_resp_gen.sv
module tb_ahb_resp_gen;
  localparam int WAIT_W   = 4;
  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 2;

  logic             hclk;
  logic             hreset;
  logic             err_clr;
  logic [CNT_W-1:0] err_cnt;
  int               checks;
  int               failures;
  int               exp_err;

  ahb_resp_gen_if #(.WAIT_W(WAIT_W)) bus ();

  ahb_resp_gen #(
    .WAIT_W  (WAIT_W),
    .MAX_WAIT(MAX_WAIT),
    .CNT_W   (CNT_W)
  ) dut (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus),
    .err_clr(err_clr),
    .err_cnt(err_cnt)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic drv(input logic sel, input logic [1:0] trans,
                     input logic [1:0] typ, input logic [WAIT_W-1:0] w);
    bus.hsel      = sel;
    bus.htrans    = trans;
    bus.resp_type = typ;
    bus.resp_wait = w;
  endtask

  task automatic chk_bus(input string tag, input logic h, input logic [1:0] r,
                         input logic d);
    checks++;
    assert ({bus.hready, bus.hresp, bus.resp_done} === {h, r, d})
    else begin
      failures++;
      $error("FAIL %s: hready/hresp/done observed %b/%b/%b expected %b/%b/%b",
             tag, bus.hready, bus.hresp, bus.resp_done, h, r, d);
    end
  endtask

  task automatic chk_cnt(input string tag);
    logic [CNT_W-1:0] e;
`ifdef AHB_RESP_ERRCNT_EN
    e = CNT_W'(exp_err);
`else
    e = '0;
`endif
    checks++;
    assert (err_cnt === e)
    else begin
      failures++;
      $error("FAIL %s: err_cnt observed %0d expected %0d", tag, err_cnt, e);
    end
  endtask

  // ERROR with zero wait: FIRST then LAST; clr is held across the LAST-entry edge.
  task automatic do_err(input string tag, input logic clr);
    drv(1'b1, 2'b10, 2'b01, 4'd0);
    tick();
    chk_bus({tag, "_first"}, 1'b0, 2'b01, 1'b0);
    drv(1'b0, 2'b00, 2'b00, 4'd0);
    err_clr = clr;
    tick();
    err_clr = 1'b0;
    if (clr) exp_err = 0;
    else if (exp_err < 3) exp_err++;
    chk_bus({tag, "_last"}, 1'b1, 2'b01, 1'b1);
    chk_cnt({tag, "_cnt"});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_err  = 0;
    hreset   = 1'b1;
    err_clr  = 1'b0;
    bus.hready_in = 1'b1;
    drv(1'b0, 2'b00, 2'b00, 4'd0);
    #1 hreset = 1'b0;
    #2;
    chk_bus("reset", 1'b1, 2'b00, 1'b0);
    chk_cnt("reset_cnt");
    tick();
    tick();
    chk_bus("reset_hold", 1'b1, 2'b00, 1'b0);
    @(negedge hclk);
    hreset = 1'b1;

    // OKAY, zero wait
    drv(1'b1, 2'b10, 2'b00, 4'd0);
    tick();
    chk_bus("okay0_last", 1'b1, 2'b00, 1'b1);
    drv(1'b0, 2'b00, 2'b00, 4'd0);
    tick();
    chk_bus("okay0_idle", 1'b1, 2'b00, 1'b0);

    // OKAY, three waits
    drv(1'b1, 2'b10, 2'b00, 4'd3);
    tick();
    chk_bus("okay3_w1", 1'b0, 2'b00, 1'b0);
    drv(1'b0, 2'b00, 2'b00, 4'd0);
    tick();
    chk_bus("okay3_w2", 1'b0, 2'b00, 1'b0);
    tick();
    chk_bus("okay3_w3", 1'b0, 2'b00, 1'b0);
    tick();
    chk_bus("okay3_last", 1'b1, 2'b00, 1'b1);
    tick();
    chk_bus("okay3_idle", 1'b1, 2'b00, 1'b0);

    // ERROR, two waits
    drv(1'b1, 2'b11, 2'b01, 4'd2);
    tick();
    chk_bus("err2_w1", 1'b0, 2'b00, 1'b0);
    drv(1'b0, 2'b00, 2'b00, 4'd0);
    tick();
    chk_bus("err2_w2", 1'b0, 2'b00, 1'b0);
    tick();
    chk_bus("err2_first", 1'b0, 2'b01, 1'b0);
    tick();
    exp_err = 1;
    chk_bus("err2_last", 1'b1, 2'b01, 1'b1);
    chk_cnt("err2_cnt");
    tick();
    chk_bus("err2_idle", 1'b1, 2'b00, 1'b0);

    // RETRY then back-to-back OKAY accepted in LAST
    drv(1'b1, 2'b10, 2'b10, 4'd0);
    tick();
    chk_bus("retry_first", 1'b0, 2'b10, 1'b0);
    drv(1'b0, 2'b00, 2'b00, 4'd0);
    tick();
    chk_bus("retry_last", 1'b1, 2'b10, 1'b1);
    drv(1'b1, 2'b10, 2'b00, 4'd0);
    tick();
    chk_bus("b2b_okay_last", 1'b1, 2'b00, 1'b1);
    drv(1'b0, 2'b00, 2'b00, 4'd0);
    tick();
    chk_bus("b2b_idle", 1'b1, 2'b00, 1'b0);

    // resp_wait=15 clamped to MAX_WAIT=4
    drv(1'b1, 2'b10, 2'b00, 4'd15);
    tick();
    drv(1'b0, 2'b00, 2'b00, 4'd0);
    for (int i = 0; i < MAX_WAIT; i++) begin
      chk_bus($sformatf("clamp_w%0d", i), 1'b0, 2'b00, 1'b0);
      tick();
    end
    chk_bus("clamp_last", 1'b1, 2'b00, 1'b1);
    tick();
    chk_bus("clamp_idle", 1'b1, 2'b00, 1'b0);

    // Transfers that must not be accepted
    drv(1'b1, 2'b01, 2'b01, 4'd2);
    tick();
    chk_bus("busy_1", 1'b1, 2'b00, 1'b0);
    tick();
    chk_bus("busy_2", 1'b1, 2'b00, 1'b0);
    drv(1'b0, 2'b10, 2'b01, 4'd0);
    tick();
    chk_bus("nosel", 1'b1, 2'b00, 1'b0);
    drv(1'b1, 2'b11, 2'b01, 4'd0);
    bus.hready_in = 1'b0;
    tick();
    chk_bus("not_ready", 1'b1, 2'b00, 1'b0);
    bus.hready_in = 1'b1;
    drv(1'b0, 2'b00, 2'b00, 4'd0);
    tick();

    // Reset during the WAIT of a SPLIT transfer
    drv(1'b1, 2'b10, 2'b11, 4'd3);
    tick();
    chk_bus("split_w1", 1'b0, 2'b00, 1'b0);
    drv(1'b0, 2'b00, 2'b00, 4'd0);
    #3 hreset = 1'b0;
    #1;
    exp_err = 0;
    chk_bus("split_rst", 1'b1, 2'b00, 1'b0);
    chk_cnt("split_rst_cnt");
    #1 hreset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_bus($sformatf("split_after%0d", i), 1'b1, 2'b00, 1'b0);
    end

    // Error counter saturation and clear priority
    do_err("sat1", 1'b0);
    do_err("sat2", 1'b0);
    do_err("sat3", 1'b0);
    do_err("sat4", 1'b0);
    do_err("clr", 1'b1);
    do_err("after_clr", 1'b0);
    tick();
    chk_bus("final_idle", 1'b1, 2'b00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
